// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS main controller: a Moore FSM that steps each instruction through
// fetch/decode/execute/memory/write-back and drives the shared-memory datapath strobes.
module multicycle_control_unit #(
  parameter int MEM_LAT = 0,
  parameter bit EXT_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_sw_q;
  logic       in_mem;
  logic       mem_done;
  logic       op_legal;

  assign in_mem   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_done = (cnt_q == LAT);

  // Counter returns to zero whenever a memory state exits, so every entry starts clean.
  assign cnt_d = (in_mem && !mem_done) ? cnt_q + 4'd1 : 4'd0;

  always_comb begin
    op_legal = 1'b0;
    case (instr_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: op_legal = 1'b1;
      OP_J, OP_ADDI:                  op_legal = EXT_OPS;
      default:                        op_legal = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      is_sw_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // The opcode is only trusted in DECODE; remember the load/store split for MEMADR.
      if (state_q == S_DECODE) is_sw_q <= (instr_op == OP_SW);
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (instr_op)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = EXT_OPS ? S_JUMP : S_FETCH;
          OP_ADDI:      state_d = EXT_OPS ? S_ADDIEX : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 commit only once the instruction word is actually valid.
        ir_write  = mem_done;
        pc_write  = mem_done;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = !op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: three instances with different
// latency/extension settings, exercised one at a time while the others sit in reset.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } out_t;

  localparam int LATS[3] = '{0, 2, 0};
  localparam bit EXTS[3] = '{1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic [5:0] instr_op = 6'b111111;
  logic       r_cur = 1'b1;
  int         sel = 0;
  logic       rsts[3];
  out_t       outs[3];

  out_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, ill;
    logic [1:0] asb, aop, pcs;
    logic [3:0] st;
    assign rsts[g] = r_cur || (sel != g);
    multicycle_control_unit #(.MEM_LAT(LATS[g]), .EXT_OPS(EXTS[g])) u_dut (
      .clk(clk), .rst(rsts[g]), .instr_op(instr_op),
      .pc_write(pw), .pc_write_cond(pwc), .i_or_d(iod), .mem_read(mr),
      .mem_write(mw), .ir_write(irw), .mem_to_reg(m2r), .reg_dst(rd),
      .reg_write(rw), .alu_src_a(asa), .alu_src_b(asb), .alu_op(aop),
      .pc_source(pcs), .illegal_op(ill), .state(st)
    );
    assign outs[g] = {st, pw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, ill};
  end

  // Expected strobes for one cycle in a given state (hand table from the controller's output list).
  function automatic out_t exp_of(input int s, input bit last, input bit ill);
    out_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      1: begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = last; e.pc_write = last; end
      2: begin e.alu_src_b = 2'b11; e.illegal = ill; end
      3, 11: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4: begin e.mem_read = 1; e.i_or_d = 1; end
      5: begin e.reg_write = 1; e.mem_to_reg = 1; end
      6: begin e.mem_write = 1; e.i_or_d = 1; end
      7: begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      8: begin e.reg_write = 1; e.reg_dst = 1; end
      9: begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
      10: begin e.pc_write = 1; e.pc_source = 2'b10; end
      12: e.reg_write = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string nm, input out_t a, input out_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %06h expected %06h", nm, sel, a, e);
    end
  endtask

  task automatic cyc(input logic r, input logic [5:0] op, input out_t e, input string nm);
    @(posedge clk);
    #1;
    r_cur    = r;
    instr_op = op;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // One instruction: the opcode is only valid during DECODE, junk elsewhere.
  task automatic run_seq(input string nm, input logic [5:0] op, input int seq[$], input bit ill);
    for (int i = 0; i < seq.size(); i++) begin
      bit last;
      last = (seq[i] == 1) && (i + 1 < seq.size()) && (seq[i+1] != 1);
      cyc(1'b0, (seq[i] == 2) ? op : 6'b111111, exp_of(seq[i], last, ill && (seq[i] == 2)),
          $sformatf("%s[%0d]", nm, i));
    end
  endtask

  task automatic start_dut(input int d);
    @(posedge clk);
    #1;
    sel   = d;
    r_cur = 1'b1;
    exp_q.push_back(exp_of(0, 1'b0, 1'b0));
    name_q.push_back($sformatf("reset_dut%0d", d));
    #1;
    check($sformatf("reset_state_dut%0d", d), outs[sel], exp_of(0, 1'b0, 1'b0));
    cyc(1'b1, 6'b000000, exp_of(0, 1'b0, 1'b0), "reset_hold");
    cyc(1'b0, 6'b000000, exp_of(0, 1'b0, 1'b0), "reset_release");
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, outs[sel], e);
    end
  end

  initial begin
    int s[$];

    // MEM_LAT=0, EXT_OPS=1
    start_dut(0);
    s = '{1, 2, 7, 8};       run_seq("rtype_l0", 6'b000000, s, 1'b0);
    s = '{1, 2, 3, 6};       run_seq("sw_l0",    6'b101011, s, 1'b0);
    s = '{1, 2, 9};          run_seq("beq_l0",   6'b000100, s, 1'b0);
    s = '{1, 2, 10};         run_seq("j_l0",     6'b000010, s, 1'b0);
    s = '{1, 2, 11, 12};     run_seq("addi_l0",  6'b001000, s, 1'b0);
    s = '{1, 2, 3, 4, 5};    run_seq("lw_l0",    6'b100011, s, 1'b0);
    s = '{1, 2};             run_seq("bad_l0",   6'b111111, s, 1'b1);
    s = '{1, 2, 7, 8};       run_seq("rtype2_l0", 6'b000000, s, 1'b0);

    // MEM_LAT=2, EXT_OPS=1
    start_dut(1);
    s = '{1, 1, 1, 2, 3, 4, 4, 4, 5}; run_seq("lw_l2",    6'b100011, s, 1'b0);
    s = '{1, 1, 1, 2, 3, 6, 6, 6};    run_seq("sw_l2",    6'b101011, s, 1'b0);
    s = '{1, 1, 1, 2, 7, 8};          run_seq("rtype_l2", 6'b000000, s, 1'b0);
    s = '{1, 1, 1, 2, 3, 4};          run_seq("lw_abort", 6'b100011, s, 1'b0);
    cyc(1'b1, 6'b100011, exp_of(0, 1'b0, 1'b0), "rst_mid_memrd");
    #1;
    check("rst_mid_memrd_async", outs[sel], exp_of(0, 1'b0, 1'b0));
    cyc(1'b0, 6'b100011, exp_of(0, 1'b0, 1'b0), "rst_released");
    s = '{1, 1, 1, 2, 9};             run_seq("beq_after_rst", 6'b000100, s, 1'b0);

    // MEM_LAT=0, EXT_OPS=0
    start_dut(2);
    s = '{1, 2};          run_seq("j_noext",    6'b000010, s, 1'b1);
    s = '{1, 2};          run_seq("addi_noext", 6'b001000, s, 1'b1);
    s = '{1, 2, 9};       run_seq("beq_noext",  6'b000100, s, 1'b0);
    s = '{1, 2, 7, 8};    run_seq("rtype_noext", 6'b000000, s, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
